// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcode values, FSM encoding and register-file geometry.
package alu_pkg;

    localparam int REG_IDX_W = 2;
    localparam int DATA_W    = 4;
    localparam int NUM_REGS  = 1 << REG_IDX_W;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_MULT  = 4'h5;
    localparam logic [3:0] OP_DIV   = 4'h6;
    localparam logic [3:0] OP_SHIFT = 4'h7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    function automatic logic op_writes_back(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_MULT, OP_DIV, OP_SHIFT: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // Opcodes whose ALU result is wider than one register spill into r[rd+1].
    function automatic logic op_two_results(input logic [3:0] op);
        case (op)
            OP_MULT, OP_DIV, OP_SHIFT: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic op_uses_carry(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Four-entry register file: two operand read ports, one debug read port,
// two ALU write ports and a direct load port that wins any address collision.
module alu_regfile
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] op_a_addr,
    input  logic [REG_IDX_W-1:0] op_b_addr,
    output logic [DATA_W-1:0]    op_a_data,
    output logic [DATA_W-1:0]    op_b_data,
    input  logic [REG_IDX_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]    dbg_data,
    input  logic                 wa_en,
    input  logic [REG_IDX_W-1:0] wa_addr,
    input  logic [DATA_W-1:0]    wa_data,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 ld_en,
    input  logic [REG_IDX_W-1:0] ld_addr,
    input  logic [DATA_W-1:0]    ld_data
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    assign op_a_data = regs_q[op_a_addr];
    assign op_b_data = regs_q[op_b_addr];
    assign dbg_data  = regs_q[dbg_addr];

    // Later assignments take priority, so the load port is applied last.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wa_en) regs_d[wa_addr] = wa_data;
        if (wb_en) regs_d[wb_addr] = wb_data;
        if (ld_en) regs_d[ld_addr] = ld_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Three-phase (IDLE/ISSUE/WRITE) sequencer driving an external ALU and writing results back.
// Define ALU_SEQ_CARRY_CHAIN_EN to feed carry_flag into alu_cin for ADD/SUB.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic [1:0] instr_rd,
    input  logic [1:0] instr_rs1,
    input  logic [1:0] instr_rs2,
    input  logic       ld_en,
    input  logic [1:0] ld_addr,
    input  logic [3:0] ld_data,
    output logic [3:0] alu_opcode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    input  logic [3:0] alu_out,
    input  logic [3:0] alu_out_2,
    input  logic       alu_cout,
    input  logic [1:0] rf_raddr,
    output logic [3:0] rf_rdata,
    output logic       carry_flag,
    output logic       done,
    output logic       busy
);

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [1:0] rd_q, rd_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic       cin_q, cin_d;
    logic       carry_q, carry_d;
    logic       wa_en, wb_en;
    logic [1:0] rd_wrap;
    logic [3:0] rs1_data, rs2_data;

    assign rd_wrap = rd_q + 2'd1;

    alu_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .op_a_addr (instr_rs1),
        .op_b_addr (instr_rs2),
        .op_a_data (rs1_data),
        .op_b_data (rs2_data),
        .dbg_addr  (rf_raddr),
        .dbg_data  (rf_rdata),
        .wa_en     (wa_en),
        .wa_addr   (rd_q),
        .wa_data   (alu_out),
        .wb_en     (wb_en),
        .wb_addr   (rd_wrap),
        .wb_data   (alu_out_2),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    // Operands are captured at handshake so later loads cannot disturb an in-flight op.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        carry_d = carry_q;
        wa_en   = 1'b0;
        wb_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    state_d = ST_ISSUE;
                    op_d    = instr_op;
                    rd_d    = instr_rd;
                    a_d     = rs1_data;
                    b_d     = rs2_data;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
                    cin_d   = op_uses_carry(instr_op) & carry_q;
`else
                    cin_d   = 1'b0;
`endif
                end
            end
            ST_ISSUE: state_d = ST_WRITE;
            ST_WRITE: begin
                state_d = ST_IDLE;
                wa_en   = op_writes_back(op_q);
                wb_en   = op_two_results(op_q);
                if (op_uses_carry(op_q)) carry_d = alu_cout;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= 4'h0;
            rd_q    <= 2'd0;
            a_q     <= 4'h0;
            b_q     <= 4'h0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
        end
    end

    assign alu_opcode  = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_cin     = cin_q;
    assign carry_flag  = carry_q;
    assign instr_ready = (state_q == ST_IDLE) && !rst;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_WRITE) && !rst;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL declare clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL declare rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL declare instr_valid input 1, instr_ready output 1: instruction handshake, transfer when both high on a rising edge.
REQ-004 SHALL declare instr_op input 4 (ALU opcode), instr_rd input 2, instr_rs1 input 2, instr_rs2 input 2 (register indices).
REQ-005 SHALL declare ld_en input 1, ld_addr input 2, ld_data input 4: direct register-file load port.
REQ-006 SHALL declare alu_opcode output 4, alu_a output 4, alu_b output 4, alu_cin output 1: registered drive into the downstream ALU.
REQ-007 SHALL declare alu_out input 4, alu_out_2 input 4, alu_cout input 1: combinational results returned by the ALU.
REQ-008 SHALL declare rf_raddr input 2, rf_rdata output 4 (combinational read of register file), carry_flag output 1, done output 1, busy output 1.

Function
REQ-009 SHALL hold a register file of four 4-bit registers r0..r3 and a 1-bit carry flag.
REQ-010 SHALL implement states IDLE, ISSUE, WRITE; IDLE->ISSUE on handshake, ISSUE->WRITE unconditionally, WRITE->IDLE unconditionally.
REQ-011 SHALL assert instr_ready only in IDLE and not during rst; busy SHALL equal (state != IDLE).
REQ-012 SHALL, on handshake in cycle N, capture op/rd/rs1/rs2 and rs1/rs2 register contents, and drive alu_opcode=op, alu_a=r[rs1], alu_b=r[rs2] from cycle N+1 (ISSUE) through WRITE.
REQ-013 SHALL, in WRITE (cycle N+2), write alu_out to r[rd]; for MULT, DIV and SHIFT additionally write alu_out_2 to r[(rd+1) mod 4].
REQ-014 SHALL update carry_flag with alu_cout in WRITE only for ADD and SUB; other opcodes leave it unchanged.
REQ-015 SHALL pulse done high for exactly the WRITE cycle; results visible on rf_rdata from cycle N+3.
REQ-016 SHALL treat unrecognised opcodes as no-writeback: full ISSUE/WRITE sequence, done pulses, no register or flag change.
REQ-017 SHALL perform ld_en writes in any state; when ld_en and a WRITE target the same register in one cycle, ld_data SHALL win.
REQ-018 SHALL sample operands at handshake, so ld_en writes during ISSUE/WRITE do not alter in-flight alu_a/alu_b.
REQ-019 SHALL, when rd=3 with a two-result opcode, wrap the second write to r0.

Reset
REQ-020 SHALL on rst clear r0..r3 and carry_flag to 0, enter IDLE, drive alu_opcode/alu_a/alu_b to 4'h0, alu_cin/done to 0.
REQ-021 SHALL on rst in ISSUE or WRITE abandon the instruction with no writeback and no done pulse; rst SHALL override ld_en.

Configuration
REQ-022 SHALL provide macro ALU_SEQ_CARRY_CHAIN_EN: defined, alu_cin = carry_flag for ADD and SUB (multi-word arithmetic); undefined, alu_cin is constant 0 and carry_flag still updates.

Structure
REQ-023 SHALL place opcode constants (values identical to the ALU opcode defines), state encoding and register-index width in shared package alu_pkg.
REQ-024 SHALL implement the register file as sub-module alu_regfile (one combinational read port plus operand read, two write ports with ld priority).

Verification
REQ-025 SHALL cover: ld r0=3, r1=5; ADD rd=2 rs1=0 rs2=1 -> alu_a=3, alu_b=5 at N+1, done at N+2, r2=4'b1000, carry_flag=0.
REQ-026 SHALL cover: r0=3, r1=5; SUB rd=2 -> r2=4'b1110, carry_flag=1; with ALU_SEQ_CARRY_CHAIN_EN a following ADD drives alu_cin=1, without it alu_cin=0.
REQ-027 SHALL cover: r0=3, r1=4; MULT rd=3 -> r3=4'b1100, r0=4'b0000 (wrap write), done once.
REQ-028 SHALL cover: instr_valid held high across back-to-back instructions -> one accept per 3 cycles, instr_ready low in ISSUE/WRITE.
REQ-029 SHALL cover: rst asserted in WRITE of ADD rd=2 -> r2=0, no done pulse, IDLE and instr_ready=1 the cycle after rst deasserts.
REQ-030 SHALL cover: ld_en to r2 with data 4'hF in same cycle as WRITE to r2 -> r2=4'hF.
